// File: rtl/snn_pkg.sv
// snn_pkg: definitions shared by the spiking-network stages (LIF neuron, STDP).
//   lif_state_t         - two-state step sequencer used by lif_neuron (IDLE, EMIT).
//   TIME_STEP_W         - width of the shared time-step counter.
//   DEFAULT_WEIGHT_SIZE - synaptic weight width; the STDP stage must use the same value.
//   ctr_width()         - counter width able to hold 0..max_val (never narrower than 1 bit).
package snn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } lif_state_t;

  localparam int TIME_STEP_W         = 8;
  localparam int DEFAULT_WEIGHT_SIZE = 16;

  function automatic int ctr_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spike_weight_sum.sv
// spike_weight_sum: combinational masked adder. Adds weights[i] for every
// set bit of spk_pre. The result is widened by clog2(N_INPUTS) bits so that
// the sum of all weights cannot overflow.
// Ports:
//   spk_pre  in  N_INPUTS              - spike mask
//   weights  in  N_INPUTS*WEIGHT_SIZE  - weight i at [i*WEIGHT_SIZE +: WEIGHT_SIZE]
//   sum      out SUM_W                 - masked weight sum
module spike_weight_sum
  import snn_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int WEIGHT_SIZE = DEFAULT_WEIGHT_SIZE,
  parameter int SUM_W       = WEIGHT_SIZE + $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0]             spk_pre,
  input  logic [N_INPUTS*WEIGHT_SIZE-1:0] weights,
  output logic [SUM_W-1:0]                sum
);

  logic [WEIGHT_SIZE-1:0] masked [N_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_mask
      assign masked[gi] = spk_pre[gi] ? weights[gi*WEIGHT_SIZE +: WEIGHT_SIZE]
                                      : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      sum = sum + SUM_W'(masked[i]);
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with the shared time-step counter.
// Each accepted step integrates the weighted presynaptic spikes (minus an
// optional leak), fires when the potential reaches THRESHOLD, then stays
// refractory for REFRAC_STEPS steps. During the single EMIT cycle that follows
// an accepted step, spk_post, spk_pre_q and the pre-step time_step are
// presented together for the STDP stage; time_step advances as EMIT ends.
// Build option: define LIF_LEAK_EN to enable leak = v >> LEAK_SHIFT;
// otherwise the neuron is a pure integrator.
// Ports:
//   clk         in  1                      - rising-edge clock
//   rst         in  1                      - synchronous active-high reset
//   step_en     in  1                      - step request (taken when step_ready)
//   spk_pre     in  N_INPUTS               - presynaptic spikes
//   weights     in  N_INPUTS*WEIGHT_SIZE   - flattened synaptic weights
//   step_ready  out 1                      - high in IDLE
//   spk_post    out 1                      - postsynaptic spike pulse (EMIT cycle)
//   spk_pre_q   out N_INPUTS               - sampled spk_pre (EMIT cycle only)
//   time_step   out TIME_STEP_W            - current step index (wraps mod 256)
//   v_mem       out POT_SIZE               - membrane potential (debug)
module lif_neuron
  import snn_pkg::*;
#(
  parameter int                  N_INPUTS     = 4,
  parameter int                  WEIGHT_SIZE  = DEFAULT_WEIGHT_SIZE,
  parameter int                  POT_SIZE     = 20,
  parameter logic [POT_SIZE-1:0] THRESHOLD    = 20'd1000,
  parameter int                  LEAK_SHIFT   = 3,
  parameter int                  REFRAC_STEPS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            step_en,
  input  logic [N_INPUTS-1:0]             spk_pre,
  input  logic [N_INPUTS*WEIGHT_SIZE-1:0] weights,
  output logic                            step_ready,
  output logic                            spk_post,
  output logic [N_INPUTS-1:0]             spk_pre_q,
  output logic [TIME_STEP_W-1:0]          time_step,
  output logic [POT_SIZE-1:0]             v_mem
);

  localparam int SUM_W = WEIGHT_SIZE + $clog2(N_INPUTS);
  // One guard bit above the wider of potential and sum, so the add cannot wrap
  // before the saturation check.
  localparam int EXT_W = ((POT_SIZE > SUM_W) ? POT_SIZE : SUM_W) + 1;
  localparam logic [EXT_W-1:0] POT_MAX_EXT = EXT_W'({POT_SIZE{1'b1}});
  localparam int REF_W = ctr_width(REFRAC_STEPS);
  localparam logic [REF_W-1:0] REFRAC_LOAD = REF_W'(REFRAC_STEPS);

`ifdef LIF_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  lif_state_t             state_reg, state_next;
  logic [POT_SIZE-1:0]    v_reg, v_next;
  logic [REF_W-1:0]       refrac_reg, refrac_next;
  logic                   spk_post_reg, spk_post_next;
  logic [N_INPUTS-1:0]    spk_pre_q_reg, spk_pre_q_next;
  logic [TIME_STEP_W-1:0] time_step_reg, time_step_next;

  logic [SUM_W-1:0]       sum;
  logic [POT_SIZE-1:0]    leak;
  logic [POT_SIZE-1:0]    v_leaked;
  logic [EXT_W-1:0]       v_ext;
  logic [POT_SIZE-1:0]    v_upd;
  logic                   fire;

  spike_weight_sum #(
    .N_INPUTS    (N_INPUTS),
    .WEIGHT_SIZE (WEIGHT_SIZE),
    .SUM_W       (SUM_W)
  ) u_sum (
    .spk_pre (spk_pre),
    .weights (weights),
    .sum     (sum)
  );

  // Candidate potential for a non-refractory step. v >> LEAK_SHIFT never
  // exceeds v, so the subtraction cannot underflow.
  always_comb begin
    leak     = LEAK_ON ? (v_reg >> LEAK_SHIFT) : '0;
    v_leaked = v_reg - leak;
    v_ext    = EXT_W'(v_leaked) + EXT_W'(sum);
    v_upd    = (v_ext > POT_MAX_EXT) ? '1 : v_ext[POT_SIZE-1:0];
    fire     = (v_upd >= THRESHOLD);
  end

  always_comb begin
    state_next     = state_reg;
    v_next         = v_reg;
    refrac_next    = refrac_reg;
    spk_post_next  = spk_post_reg;
    spk_pre_q_next = spk_pre_q_reg;
    time_step_next = time_step_reg;

    case (state_reg)
      IDLE: begin
        if (step_en) begin
          state_next     = EMIT;
          // Presynaptic spikes are reported even while refractory.
          spk_pre_q_next = spk_pre;
          if (refrac_reg != '0) begin
            v_next        = '0;
            refrac_next   = refrac_reg - 1'b1;
            spk_post_next = 1'b0;
          end else if (fire) begin
            v_next        = '0;
            refrac_next   = REFRAC_LOAD;
            spk_post_next = 1'b1;
          end else begin
            v_next        = v_upd;
            spk_post_next = 1'b0;
          end
        end
      end
      EMIT: begin
        // Requests arriving here are dropped, not queued.
        state_next     = IDLE;
        time_step_next = time_step_reg + 1'b1;
        spk_post_next  = 1'b0;
        spk_pre_q_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      v_reg         <= '0;
      refrac_reg    <= '0;
      spk_post_reg  <= 1'b0;
      spk_pre_q_reg <= '0;
      time_step_reg <= '0;
    end else begin
      state_reg     <= state_next;
      v_reg         <= v_next;
      refrac_reg    <= refrac_next;
      spk_post_reg  <= spk_post_next;
      spk_pre_q_reg <= spk_pre_q_next;
      time_step_reg <= time_step_next;
    end
  end

  assign step_ready = (state_reg == IDLE);
  assign spk_post   = spk_post_reg;
  assign spk_pre_q  = spk_pre_q_reg;
  assign time_step  = time_step_reg;
  assign v_mem      = v_reg;

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed self-checking bench for lif_neuron with
// THRESHOLD=100, all weights 40, REFRAC_STEPS=2, LEAK_SHIFT=3.
// Expected potentials are hand-computed for both leak build options.
module tb_lif_neuron;

  localparam int N  = 4;
  localparam int WS = 16;
  localparam int PS = 20;

`ifdef LIF_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            step_en = 1'b0;
  logic [N-1:0]    spk_pre = '0;
  logic [N*WS-1:0] weights = {N{16'd40}};
  logic            step_ready;
  logic            spk_post;
  logic [N-1:0]    spk_pre_q;
  logic [7:0]      time_step;
  logic [PS-1:0]   v_mem;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lif_neuron #(
    .N_INPUTS     (N),
    .WEIGHT_SIZE  (WS),
    .POT_SIZE     (PS),
    .THRESHOLD    (20'd100),
    .LEAK_SHIFT   (3),
    .REFRAC_STEPS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_en    (step_en),
    .spk_pre    (spk_pre),
    .weights    (weights),
    .step_ready (step_ready),
    .spk_post   (spk_post),
    .spk_pre_q  (spk_pre_q),
    .time_step  (time_step),
    .v_mem      (v_mem)
  );

  // Issue one step; returns 1ns into the EMIT cycle (outputs valid).
  task automatic start_step(input logic [N-1:0] pre);
    @(negedge clk);
    step_en = 1'b1;
    spk_pre = pre;
    @(posedge clk);
    #1;
    step_en = 1'b0;
    spk_pre = '0;
    $display("[TB] step pre=%b post=%b pre_q=%b ts=%0d v=%0d", pre, spk_post, spk_pre_q, time_step, v_mem);
  endtask

  // Leave EMIT; returns 1ns into the following IDLE cycle.
  task automatic end_step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (step_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", step_ready); end
    tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL reset_post: got %b want 0", spk_post); end
    tests_run++; if (spk_pre_q !== 4'b0000) begin tests_failed++; $display("FAIL reset_pre_q: got %b want 0000", spk_pre_q); end
    tests_run++; if (time_step !== 8'd0) begin tests_failed++; $display("FAIL reset_ts: got %0d want 0", time_step); end
    tests_run++; if (v_mem !== 20'd0) begin tests_failed++; $display("FAIL reset_v: got %0d want 0", v_mem); end
    $display("[TB] reset done");
  endtask

  task automatic test_integrate;
    logic [PS-1:0] e2;
    e2 = LEAK ? 20'd75 : 20'd80;   // 40 - (40>>3) + 40 with leak
    start_step(4'b0001);
    tests_run++; if (v_mem !== 20'd40) begin tests_failed++; $display("FAIL integ_v1: got %0d want 40", v_mem); end
    tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL integ_post1: got %b want 0", spk_post); end
    tests_run++; if (spk_pre_q !== 4'b0001) begin tests_failed++; $display("FAIL integ_pre_q1: got %b want 0001", spk_pre_q); end
    tests_run++; if (time_step !== 8'd0) begin tests_failed++; $display("FAIL integ_ts1: got %0d want 0", time_step); end
    end_step;
    tests_run++; if (time_step !== 8'd1) begin tests_failed++; $display("FAIL integ_ts_inc: got %0d want 1", time_step); end
    tests_run++; if (spk_pre_q !== 4'b0000) begin tests_failed++; $display("FAIL integ_pre_q_clr: got %b want 0000", spk_pre_q); end
    start_step(4'b0001);
    tests_run++; if (v_mem !== e2) begin tests_failed++; $display("FAIL integ_v2: got %0d want %0d", v_mem, e2); end
    tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL integ_post2: got %b want 0", spk_post); end
    end_step;
    start_step(4'b0011);
    tests_run++; if (spk_post !== 1'b1) begin tests_failed++; $display("FAIL integ_fire: got %b want 1", spk_post); end
    tests_run++; if (time_step !== 8'd2) begin tests_failed++; $display("FAIL integ_fire_ts: got %0d want 2", time_step); end
    tests_run++; if (v_mem !== 20'd0) begin tests_failed++; $display("FAIL integ_fire_v: got %0d want 0", v_mem); end
    tests_run++; if (step_ready !== 1'b0) begin tests_failed++; $display("FAIL integ_emit_ready: got %b want 0", step_ready); end
    end_step;
    tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL integ_pulse_width: got %b want 0", spk_post); end
  endtask

  task automatic test_refractory;
    for (int k = 0; k < 2; k++) begin
      start_step(4'b1111);
      tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL refrac_post%0d: got %b want 0", k, spk_post); end
      tests_run++; if (v_mem !== 20'd0) begin tests_failed++; $display("FAIL refrac_v%0d: got %0d want 0", k, v_mem); end
      tests_run++; if (spk_pre_q !== 4'b1111) begin tests_failed++; $display("FAIL refrac_pre_q%0d: got %b want 1111", k, spk_pre_q); end
      end_step;
    end
    start_step(4'b1111);
    tests_run++; if (spk_post !== 1'b1) begin tests_failed++; $display("FAIL refrac_refire: got %b want 1", spk_post); end
    tests_run++; if (time_step !== 8'd5) begin tests_failed++; $display("FAIL refrac_refire_ts: got %0d want 5", time_step); end
    end_step;
  endtask

  task automatic test_leak;
    logic [PS-1:0] e;
    e = LEAK ? 20'd70 : 20'd80;    // 80 - (80>>3) with leak
    start_step(4'b0000); end_step; // two refractory steps after the last spike
    start_step(4'b0000); end_step;
    start_step(4'b0011);
    tests_run++; if (v_mem !== 20'd80) begin tests_failed++; $display("FAIL leak_pre_v: got %0d want 80", v_mem); end
    end_step;
    start_step(4'b0000);
    tests_run++; if (v_mem !== e) begin tests_failed++; $display("FAIL leak_v: got %0d want %0d", v_mem, e); end
    end_step;
  endtask

  task automatic test_back_to_back;
    int acc;
    int bad;
    acc = 0;
    bad = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    step_en = 1'b1;
    spk_pre = '0;
    for (int i = 0; i < 512; i++) begin
      if (step_ready === 1'b1) acc++;
      if (step_ready !== ((i % 2) == 0)) bad++;
      if (i == 510) begin
        tests_run++; if (time_step !== 8'd255) begin tests_failed++; $display("FAIL b2b_ts255: got %0d want 255", time_step); end
      end
      @(negedge clk);
    end
    step_en = 1'b0;
    $display("[TB] back-to-back accepted=%0d ts=%0d", acc, time_step);
    tests_run++; if (acc !== 256) begin tests_failed++; $display("FAIL b2b_accepted: got %0d want 256", acc); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL b2b_pattern: got %0d bad cycles want 0", bad); end
    tests_run++; if (time_step !== 8'd0) begin tests_failed++; $display("FAIL b2b_wrap: got %0d want 0", time_step); end
  endtask

  task automatic test_reset_mid_emit;
    start_step(4'b0011); end_step;  // v = 80
    start_step(4'b0011);            // 160 (or 150 with leak) -> fires
    tests_run++; if (spk_post !== 1'b1) begin tests_failed++; $display("FAIL rst_emit_pre_fire: got %b want 1", spk_post); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++; if (spk_post !== 1'b0) begin tests_failed++; $display("FAIL rst_emit_post: got %b want 0", spk_post); end
    tests_run++; if (time_step !== 8'd0) begin tests_failed++; $display("FAIL rst_emit_ts: got %0d want 0", time_step); end
    tests_run++; if (v_mem !== 20'd0) begin tests_failed++; $display("FAIL rst_emit_v: got %0d want 0", v_mem); end
    tests_run++; if (spk_pre_q !== 4'b0000) begin tests_failed++; $display("FAIL rst_emit_pre_q: got %b want 0000", spk_pre_q); end
    tests_run++; if (step_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_emit_ready: got %b want 1", step_ready); end
  endtask

  initial begin
    test_reset;
    test_integrate;
    test_refractory;
    test_leak;
    test_back_to_back;
    test_reset_mid_emit;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
